reset_sequencer: RTL and testbench

RESET_SEQUENCER -- requirements
Module: reset_sequencer

---
 rtl/reset_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_reset_sequencer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// Reset sequencer: waits for clock lock, holds a power-up delay, then releases
// a chain of per-domain resets one at a time. Lock loss, a debounced external
// pad reset or a software request restarts the whole sequence.
module reset_sequencer #(
  parameter int CNT_WIDTH  = 24,
  parameter int NUM_LOCK   = 2,
  parameter int NUM_STAGES = 3,
  parameter int STAGE_GAP  = 16,
  parameter int DEBOUNCE   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ext_rst_n,
  input  logic [NUM_LOCK-1:0]   locked,
  input  logic                  sw_rst_req,
  output logic                  ext_rst_oe,
  output logic [NUM_STAGES-1:0] rst_out,
  output logic                  clk_ok,
  output logic                  busy,
  output logic [1:0]            cause
);

  localparam int GAP_W = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
  localparam int DEB_W = $clog2(DEBOUNCE + 1);

  localparam logic [GAP_W-1:0]      GAP_LAST  = GAP_W'(STAGE_GAP - 1);
  localparam logic [DEB_W-1:0]      DEB_FULL  = DEB_W'(DEBOUNCE);
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = {CNT_WIDTH{1'b1}};
  localparam logic [NUM_STAGES-1:0] ALL_ONES  = {NUM_STAGES{1'b1}};
  // Pattern with only stage 0 released; all zeros when there is a single stage,
  // which makes the COUNT exit land directly in RUN.
  localparam logic [NUM_STAGES-1:0] FIRST_REL = ALL_ONES << 1;

  localparam logic [1:0] CAUSE_RESET = 2'd0;
  localparam logic [1:0] CAUSE_LOCK  = 2'd1;
  localparam logic [1:0] CAUSE_EXT   = 2'd2;
  localparam logic [1:0] CAUSE_SW    = 2'd3;

  typedef enum logic [1:0] {
    ST_HOLD  = 2'd0,
    ST_COUNT = 2'd1,
    ST_STAGE = 2'd2,
    ST_RUN   = 2'd3
  } state_t;

  state_t                  state_reg, state_next;
  logic [CNT_WIDTH-1:0]    cnt_reg, cnt_next;
  logic [GAP_W-1:0]        gap_reg, gap_next;
  logic [NUM_STAGES-1:0]   rst_out_reg, rst_out_next;
  logic                    ext_rst_oe_reg, ext_rst_oe_next;
  logic                    busy_reg, busy_next;
  logic [1:0]              cause_reg, cause_next;

  logic [1:0]              sync_reg;
  logic [DEB_W-1:0]        deb_reg;
  logic                    ext_sync;
  logic                    ext_event;
  logic                    restart;
  logic [1:0]              restart_cause;

  assign clk_ok    = &locked;
  assign ext_sync  = sync_reg[1];
  assign ext_event = (deb_reg == DEB_FULL);

  // Two-flop synchroniser for the asynchronous pad level; idles high.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_reg <= 2'b11;
    end else begin
      sync_reg <= {sync_reg[0], ext_rst_n};
    end
  end

  // Count consecutive synchronised-low cycles; ignore the pad while we drive it.
  always_ff @(posedge clk) begin
    if (reset) begin
      deb_reg <= '0;
    end else if (ext_rst_oe_reg || ext_sync) begin
      deb_reg <= '0;
    end else if (deb_reg != DEB_FULL) begin
      deb_reg <= deb_reg + DEB_W'(1);
    end
  end

  // Next-state and registered-output decode; restart events pre-empt normal flow.
  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    gap_next        = gap_reg;
    rst_out_next    = rst_out_reg;
    ext_rst_oe_next = ext_rst_oe_reg;
    cause_next      = cause_reg;
    restart         = 1'b0;
    restart_cause   = cause_reg;

    if (state_reg != ST_HOLD) begin
      if (!clk_ok) begin
        restart       = 1'b1;
        restart_cause = CAUSE_LOCK;
      end else if (ext_event) begin
        restart       = 1'b1;
        restart_cause = CAUSE_EXT;
      end else if (sw_rst_req && (state_reg == ST_RUN)) begin
        restart       = 1'b1;
        restart_cause = CAUSE_SW;
      end
    end

    if (restart) begin
      state_next      = ST_HOLD;
      cnt_next        = '0;
      gap_next        = '0;
      rst_out_next    = ALL_ONES;
      ext_rst_oe_next = 1'b1;
      cause_next      = restart_cause;
    end else begin
      case (state_reg)
        ST_HOLD: begin
          cnt_next        = '0;
          gap_next        = '0;
          rst_out_next    = ALL_ONES;
          ext_rst_oe_next = 1'b1;
          if (clk_ok) begin
            state_next = ST_COUNT;
          end
        end
        ST_COUNT: begin
          if (cnt_reg == CNT_MAX) begin
            // Counter saturates here; only HOLD entry clears it.
            gap_next        = '0;
            ext_rst_oe_next = 1'b0;
            rst_out_next    = FIRST_REL;
            state_next      = (FIRST_REL == '0) ? ST_RUN : ST_STAGE;
          end else begin
            cnt_next        = cnt_reg + CNT_WIDTH'(1);
            // Pad is driven for the first half of the delay only.
            ext_rst_oe_next = ~cnt_next[CNT_WIDTH-1];
          end
        end
        ST_STAGE: begin
          ext_rst_oe_next = 1'b0;
          if (gap_reg == GAP_LAST) begin
            gap_next     = '0;
            rst_out_next = rst_out_reg << 1;
            if (rst_out_next == '0) begin
              state_next = ST_RUN;
            end
          end else begin
            gap_next = gap_reg + GAP_W'(1);
          end
        end
        ST_RUN: begin
          rst_out_next    = '0;
          ext_rst_oe_next = 1'b0;
        end
        default: begin
          state_next = ST_HOLD;
        end
      endcase
    end

    busy_next = (state_next != ST_RUN);
  end

  // State and output registers; reset overrides every event and transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_HOLD;
      cnt_reg        <= '0;
      gap_reg        <= '0;
      rst_out_reg    <= ALL_ONES;
      ext_rst_oe_reg <= 1'b1;
      busy_reg       <= 1'b1;
      cause_reg      <= CAUSE_RESET;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      gap_reg        <= gap_next;
      rst_out_reg    <= rst_out_next;
      ext_rst_oe_reg <= ext_rst_oe_next;
      busy_reg       <= busy_next;
      cause_reg      <= cause_next;
    end
  end

  assign rst_out    = rst_out_reg;
  assign ext_rst_oe = ext_rst_oe_reg;
  assign busy       = busy_reg;
  assign cause      = cause_reg;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with a short counter and stage gap.
// Each table row is applied at the falling edge and checked just after the
// following rising edge.
module tb_reset_sequencer;

  localparam int CW = 4;
  localparam int NL = 2;
  localparam int NS = 3;
  localparam int SG = 4;
  localparam int DB = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ext_rst_n = 1'b1;
  logic [NL-1:0] locked = '0;
  logic          sw_rst_req = 1'b0;
  logic          ext_rst_oe;
  logic [NS-1:0] rst_out;
  logic          clk_ok;
  logic          busy;
  logic [1:0]    cause;

  reset_sequencer #(
    .CNT_WIDTH (CW),
    .NUM_LOCK  (NL),
    .NUM_STAGES(NS),
    .STAGE_GAP (SG),
    .DEBOUNCE  (DB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ext_rst_n (ext_rst_n),
    .locked    (locked),
    .sw_rst_req(sw_rst_req),
    .ext_rst_oe(ext_rst_oe),
    .rst_out   (rst_out),
    .clk_ok    (clk_ok),
    .busy      (busy),
    .cause     (cause)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic       rst;
    logic       ext_n;
    logic [1:0] lck;
    logic       sw;
    logic [2:0] e_rst;
    logic       e_oe;
    logic       e_busy;
    logic [1:0] e_cause;
  } vec_t;

  vec_t vq[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic void push(string tag, logic rst, logic ext_n, logic [1:0] lck, logic sw,
                               logic [2:0] e_rst, logic e_oe, logic e_busy, logic [1:0] e_cause);
    vec_t v;
    v.tag = tag; v.rst = rst; v.ext_n = ext_n; v.lck = lck; v.sw = sw;
    v.e_rst = e_rst; v.e_oe = e_oe; v.e_busy = e_busy; v.e_cause = e_cause;
    vq.push_back(v);
  endfunction

  // Power-up sequence from HOLD with lock present: 16 COUNT cycles (pad driven
  // for the first 8), then 111->110->100->000 at 4-cycle spacing.
  // sw_at >= 0 pulses sw_rst_req on that COUNT row; full=0 stops at the first 100 row.
  function automatic void add_seq(string tag, logic [1:0] cz, int sw_at, bit full);
    for (int k = 0; k < 16; k++) push(tag, 1'b0, 1'b1, 2'b11, (k == sw_at), 3'b111, (k < 8), 1'b1, cz);
    for (int k = 0; k < 4; k++)  push(tag, 1'b0, 1'b1, 2'b11, 1'b0, 3'b110, 1'b0, 1'b1, cz);
    if (!full) begin
      push(tag, 1'b0, 1'b1, 2'b11, 1'b0, 3'b100, 1'b0, 1'b1, cz);
      return;
    end
    for (int k = 0; k < 4; k++)  push(tag, 1'b0, 1'b1, 2'b11, 1'b0, 3'b100, 1'b0, 1'b1, cz);
    push(tag, 1'b0, 1'b1, 2'b11, 1'b0, 3'b000, 1'b0, 1'b0, cz);
  endfunction

  function automatic void add_run(string tag, int n, logic [1:0] cz);
    for (int k = 0; k < n; k++) push(tag, 1'b0, 1'b1, 2'b11, 1'b0, 3'b000, 1'b0, 1'b0, cz);
  endfunction

  task automatic check(input string tag, input logic [2:0] e_rst, input logic e_oe,
                       input logic e_busy, input logic [1:0] e_cause, input logic e_ok);
    n_vec++;
    if (rst_out !== e_rst || ext_rst_oe !== e_oe || busy !== e_busy ||
        cause !== e_cause || clk_ok !== e_ok) begin
      n_bad++;
      $display("FAIL vec %0d %s: got rst_out=%b ext_rst_oe=%b busy=%b cause=%0d clk_ok=%b, want %b %b %b %0d %b",
               n_vec, tag, rst_out, ext_rst_oe, busy, cause, clk_ok, e_rst, e_oe, e_busy, e_cause, e_ok);
    end else begin
      $display("vec %0d %s: rst_out=%b ext_rst_oe=%b busy=%b cause=%0d clk_ok=%b",
               n_vec, tag, rst_out, ext_rst_oe, busy, cause, clk_ok);
    end
  endtask

  task automatic run_table();
    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      reset      = vq[i].rst;
      ext_rst_n  = vq[i].ext_n;
      locked     = vq[i].lck;
      sw_rst_req = vq[i].sw;
      @(posedge clk);
      #1;
      check(vq[i].tag, vq[i].e_rst, vq[i].e_oe, vq[i].e_busy, vq[i].e_cause, &vq[i].lck);
    end
    vq.delete();
  endtask

  int  edge_hit;
  bit  hit;

  initial begin
    // Reset, hold while unlocked, then full power-up sequence.
    push("reset",      1'b1, 1'b1, 2'b00, 1'b0, 3'b111, 1'b1, 1'b1, 2'd0);
    push("hold_nolock",1'b0, 1'b1, 2'b00, 1'b0, 3'b111, 1'b1, 1'b1, 2'd0);
    push("hold_part",  1'b0, 1'b1, 2'b01, 1'b0, 3'b111, 1'b1, 1'b1, 2'd0);
    add_seq("powerup", 2'd0, -1, 1'b1);
    add_run("run0", 2, 2'd0);
    // One-cycle lock loss, stay in HOLD while unlocked, sw pulse in COUNT ignored.
    push("lock_loss",  1'b0, 1'b1, 2'b10, 1'b0, 3'b111, 1'b1, 1'b1, 2'd1);
    push("hold_lock1", 1'b0, 1'b1, 2'b01, 1'b0, 3'b111, 1'b1, 1'b1, 2'd1);
    add_seq("relock_swcnt", 2'd1, 5, 1'b1);
    add_run("run1", 2, 2'd1);
    // Software restart from RUN.
    push("sw_run",     1'b0, 1'b1, 2'b11, 1'b1, 3'b111, 1'b1, 1'b1, 2'd3);
    add_seq("after_sw", 2'd3, -1, 1'b1);
    add_run("run3", 1, 2'd3);
    // Lock loss outranks a simultaneous software request.
    push("lock_vs_sw", 1'b0, 1'b1, 2'b01, 1'b1, 3'b111, 1'b1, 1'b1, 2'd1);
    add_seq("after_lk", 2'd1, -1, 1'b1);
    // Three-cycle pad glitch is filtered out.
    for (int k = 0; k < 3; k++) push("ext_short", 1'b0, 1'b0, 2'b11, 1'b0, 3'b000, 1'b0, 1'b0, 2'd1);
    for (int k = 0; k < 4; k++) push("ext_quiet", 1'b0, 1'b1, 2'b11, 1'b0, 3'b000, 1'b0, 1'b0, 2'd1);
    run_table();

    // Pad held low 6 cycles from RUN: the restart edge must be DEBOUNCE+2
    // edges after the first edge that samples the low pad.
    @(negedge clk);
    reset = 1'b0; locked = 2'b11; sw_rst_req = 1'b0; ext_rst_n = 1'b0;
    hit = 1'b0;
    edge_hit = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (rst_out === 3'b111) begin
        hit = 1'b1;
        edge_hit = i;
        break;
      end
      @(negedge clk);
      if (i >= 6) ext_rst_n = 1'b1;
    end
    ext_rst_n = 1'b1;
    n_vec++;
    if (!hit || (edge_hit - 1) != DB + 2) begin
      n_bad++;
      $display("FAIL ext_latency: restart %0d edges after first low sample (seen=%0d), want %0d",
               edge_hit - 1, hit, DB + 2);
    end else begin
      $display("vec %0d ext_latency: restart %0d edges after first low sample", n_vec, edge_hit - 1);
    end
    n_vec++;
    if (cause !== 2'd2 || ext_rst_oe !== 1'b1 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL ext_cause: got cause=%0d ext_rst_oe=%b busy=%b, want 2 1 1", cause, ext_rst_oe, busy);
    end else begin
      $display("vec %0d ext_cause: cause=%0d ext_rst_oe=%b busy=%b", n_vec, cause, ext_rst_oe, busy);
    end

    // Reset in the middle of STAGE, then a clean restart from COUNT.
    add_seq("to_stage", 2'd2, -1, 1'b0);
    push("reset_stage", 1'b1, 1'b1, 2'b11, 1'b0, 3'b111, 1'b1, 1'b1, 2'd0);
    add_seq("after_rst", 2'd0, -1, 1'b1);
    add_run("run_end", 2, 2'd0);
    run_table();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
